wb_demux8x64: RTL and testbench
===============================

# wb_demux8x64

Write-side counterpart to the 8:1 × 64-bit read selector in the register datapath. Accepts a stream of (3-bit select, 64-bit data) write requests on a valid/ready handshake, decodes the select into a one-hot enable, and stores the data into one of eight 64-bit registers. The eight registers drive the read selector's inputs directly. Per-entry valid flags let downstream logic tell written slots from stale ones.

## Interface
Parameters:
- WIDTH, 64, data width of each slot
- BUF_DEPTH, 2, input buffer depth; used only when WB_BUF_EN is defined

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  write request present
- in_ready  output  1  block accepts the request this cycle
- in_sel  input  3  destination slot, 0–7
- in_data  input  WIDTH  write data
- hold  input  1  pipeline stall; no slot is written while high
- clr_valid  input  1  clear all valid flags, one-cycle pulse
- out0 … out7  output  WIDTH  slot contents; feed read selector in0–in7
- out_valid  output  8  per-slot valid flag; bit n belongs to outN
- busy  output  1  a request is accepted or buffered but not yet written

## Operation
- Accept: in_valid && in_ready at a rising edge.
- Decoder: one-hot enable en[n] = (wsel == n). Exactly one slot is written per write cycle. Every other slot holds its value.
- Write: on the edge, the chosen slot gets the data and its out_valid bit is set to 1.
- clr_valid: at the edge, clears every out_valid bit except the slot being written on that same edge. A write wins over a clear.
- Slot data is never cleared except by reset.
- Repeated writes to the same slot: last write wins, in acceptance order.
- Write counter: none. busy = buffer non-empty, or an accept is pending under hold.

## Timing
- Reset, asynchronous:
  - out0–out7 = 0
  - out_valid = 8'h00
  - buffer empty
  - busy = 0
  - in_ready = 0 while reset is high
- Reset mid-operation: buffered writes are discarded; nothing is written after reset asserts.
- Unbuffered (WB_BUF_EN undefined):
  - in_ready = !hold && !reset, combinational.
  - An accepted write is visible on outN and out_valid the next cycle (1-cycle latency).
  - busy = 0 always.
- Buffered (WB_BUF_EN defined):
  - in_ready = !full.
  - Buffer empty and hold = 0: the accepted request is written on the same edge (1-cycle latency, bypass).
  - Otherwise the request is enqueued. The oldest entry drains one per cycle while hold = 0.
  - A bypass write never overtakes a queued entry.
  - Full with simultaneous drain: in_ready stays 0 that cycle (no pass-through at full).
  - Empty with hold = 1: the request is enqueued.
- hold only gates writes. clr_valid is honoured during hold.

## Configuration
- WB_BUF_EN defined: BUF_DEPTH-entry FIFO on the input (pointers, count, full/empty) with empty bypass. Upstream may keep issuing during a stall until the buffer fills.
- WB_BUF_EN undefined: no storage before the slots. Backpressure is hold itself.

## Structure
- Shared package wb_pkg:
  - WB_SLOTS = 8
  - WB_SEL_W = 3
  - typedef wb_req_t: struct {sel, data}
  - one-hot decode function dec3to8
- Sub-module wb_req_fifo: synchronous FIFO of wb_req_t, depth BUF_DEPTH. Instantiated only under WB_BUF_EN.
- Top: decoder, eight slot registers with enables, valid-flag register, busy logic.

## Test plan
- Reset, then write sel = 3, data = 64'hDEAD_BEEF_0000_0003: next cycle out3 = that value, out_valid = 8'h08, other outs = 0.
- Write all slots n = 0..7 with data = n × 64'h0101…01 on consecutive cycles, then pulse clr_valid while writing slot 5: out_valid = 8'h20, all data intact.
- hold = 1 for 4 cycles with in_valid = 1:
  - unbuffered: in_ready = 0 and no write occurs;
  - buffered: two requests are accepted, then in_ready = 0; after release, slots update on the two following cycles in order.
- Same slot written back-to-back (sel = 6, data A then B; buffered, stalled): out6 = B after drain.
- Assert reset asynchronously mid-cycle with buffered entries: outputs go to 0 immediately, out_valid = 0, busy = 0; the queued writes never appear.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared slot constants, request type and select decoder for wb_demux8x64
package wb_pkg;

  localparam int WB_SLOTS  = 8;
  localparam int WB_SEL_W  = 3;
  localparam int WB_DATA_W = 64;

  // One queued write request: destination slot plus payload
  typedef struct packed {
    logic [WB_SEL_W-1:0]  sel;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  // Select to one-hot slot enable
  function automatic logic [WB_SLOTS-1:0] dec3to8(input logic [WB_SEL_W-1:0] sel);
    logic [WB_SLOTS-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// rtl/wb_req_fifo.sv - synchronous FIFO of write requests in front of the slot registers
module wb_req_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    i_push,
  input  wb_req_t i_push_req,
  input  logic    i_pop,
  output wb_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_req_t       r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  // Entry storage needs no reset: occupancy decides what is readable
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_req;
    end
  end

  // Circular pointers and occupancy count; reset drops every queued entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_demux8x64.sv
// rtl/wb_demux8x64.sv - 1:8 x 64-bit write demux into slot registers; WB_BUF_EN adds an input FIFO
module wb_demux8x64
  import wb_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WB_SEL_W-1:0] in_sel,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                hold,
  input  logic                clr_valid,
  output logic [WIDTH-1:0]    out0,
  output logic [WIDTH-1:0]    out1,
  output logic [WIDTH-1:0]    out2,
  output logic [WIDTH-1:0]    out3,
  output logic [WIDTH-1:0]    out4,
  output logic [WIDTH-1:0]    out5,
  output logic [WIDTH-1:0]    out6,
  output logic [WIDTH-1:0]    out7,
  output logic [WB_SLOTS-1:0] out_valid,
  output logic                busy
);

  logic                w_accept;
  logic                w_wr_en;
  logic [WB_SEL_W-1:0] w_wr_sel;
  logic [WIDTH-1:0]    w_wr_data;
  logic [WB_SLOTS-1:0] w_wr_onehot;

  logic [WIDTH-1:0]    r_slot [WB_SLOTS];
  logic [WB_SLOTS-1:0] r_valid;

`ifdef WB_BUF_EN
  wb_req_t w_in_req;
  wb_req_t w_head;
  logic    w_full;
  logic    w_empty;
  logic    w_push;
  logic    w_pop;
  logic    w_bypass;

  assign in_ready = !w_full && !reset;
  assign w_accept = in_valid && in_ready;
  assign w_in_req = '{sel: in_sel, data: in_data};

  // Queued entries always drain first so a bypass can never overtake them
  assign w_pop    = !w_empty && !hold;
  assign w_bypass = w_accept && w_empty && !hold;
  assign w_push   = w_accept && !w_bypass;

  assign w_wr_en   = w_pop || w_bypass;
  assign w_wr_sel  = w_pop ? w_head.sel  : in_sel;
  assign w_wr_data = w_pop ? w_head.data : in_data;
  assign busy      = !w_empty || (w_accept && hold);

  wb_req_fifo #(
    .DEPTH      (BUF_DEPTH)
  ) u_req_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_req (w_in_req),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );
`else
  // No storage: a stall simply refuses the request
  assign in_ready  = !hold && !reset;
  assign w_accept  = in_valid && in_ready;
  assign w_wr_en   = w_accept;
  assign w_wr_sel  = in_sel;
  assign w_wr_data = in_data;
  assign busy      = 1'b0;
`endif

  assign w_wr_onehot = w_wr_en ? dec3to8(w_wr_sel) : '0;

  // Slot registers: only the decoded slot loads, the rest hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WB_SLOTS; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WB_SLOTS; i++) begin
        if (w_wr_onehot[i]) begin
          r_slot[i] <= w_wr_data;
        end
      end
    end
  end

  // Valid flags: a same-edge write survives the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (clr_valid) begin
      r_valid <= w_wr_onehot;
    end else begin
      r_valid <= r_valid | w_wr_onehot;
    end
  end

  assign out0      = r_slot[0];
  assign out1      = r_slot[1];
  assign out2      = r_slot[2];
  assign out3      = r_slot[3];
  assign out4      = r_slot[4];
  assign out5      = r_slot[5];
  assign out6      = r_slot[6];
  assign out7      = r_slot[7];
  assign out_valid = r_valid;

endmodule

// File: tb/tb_wb_demux8x64.sv
// tb/tb_wb_demux8x64.sv - self-checking bench for wb_demux8x64 (default build or WB_BUF_EN)
`timescale 1ns/1ps
module tb_wb_demux8x64;

  localparam int W     = 64;
  localparam int DEPTH = 2;
  localparam logic [W-1:0] PAT = 64'h0101_0101_0101_0101;
`ifdef WB_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic         clk       = 1'b0;
  logic         reset     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         hold      = 1'b0;
  logic         clr_valid = 1'b0;
  logic [2:0]   in_sel    = 3'd0;
  logic [W-1:0] in_data   = '0;
  logic         in_ready;
  logic         busy;
  logic [7:0]   out_valid;
  logic [W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [W-1:0] outs [8];

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;
  assign outs[4] = out4;
  assign outs[5] = out5;
  assign outs[6] = out6;
  assign outs[7] = out7;

  wb_demux8x64 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .hold      (hold),
    .clr_valid (clr_valid),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out5      (out5),
    .out6      (out6),
    .out7      (out7),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: slot array, valid array, and a request queue in acceptance order
  typedef struct packed {
    logic [2:0]   sel;
    logic [W-1:0] data;
  } req_t;

  logic [W-1:0] m_slot  [8];
  bit           m_valid [8];
  req_t         m_q [$];

  function automatic logic [7:0] m_valid_bits();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic bit exp_ready();
    if (reset) return 1'b0;
    if (BUF) return (m_q.size() < DEPTH);
    return !hold;
  endfunction

  function automatic bit exp_busy();
    if (!BUF) return 1'b0;
    return (m_q.size() > 0) || (in_valid && exp_ready() && hold);
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int   w;
    req_t r;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_slot[i]  = '0;
        m_valid[i] = 1'b0;
      end
      m_q.delete();
    end else begin
      w = -1;
      r = '0;
      if (BUF) begin
        if (in_valid && m_q.size() < DEPTH) m_q.push_back({in_sel, in_data});
        if (!hold && m_q.size() > 0) begin
          r = m_q.pop_front();
          w = int'(r.sel);
        end
      end else if (in_valid && !hold) begin
        r = {in_sel, in_data};
        w = int'(in_sel);
      end
      if (clr_valid) begin
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      end
      if (w >= 0) begin
        m_slot[w]  = r.data;
        m_valid[w] = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      for (int i = 0; i < 8; i++) chk($sformatf("model_out%0d", i), outs[i], m_slot[i]);
      chk("model_out_valid", {56'd0, out_valid}, {56'd0, m_valid_bits()});
      chk("model_in_ready", {63'd0, in_ready}, {63'd0, exp_ready()});
      chk("model_busy", {63'd0, busy}, {63'd0, exp_busy()});
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_slot[i]  = '0;
      m_valid[i] = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, '0);
    chk("rst_out_valid", {56'd0, out_valid}, '0);
    chk("rst_busy", {63'd0, busy}, '0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_out%0d", i), outs[i], '0);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Single write to slot 3
    in_valid = 1'b1;
    in_sel   = 3'd3;
    in_data  = 64'hDEAD_BEEF_0000_0003;
    tick();
    in_valid = 1'b0;
    chk("first_out3", out3, 64'hDEAD_BEEF_0000_0003);
    chk("first_valid", {56'd0, out_valid}, 64'h08);
    chk("first_out0", out0, '0);
    chk("first_out7", out7, '0);

    // Fill all slots, then clear valids while rewriting slot 5
    for (int n = 0; n < 8; n++) begin
      in_valid = 1'b1;
      in_sel   = 3'(n);
      in_data  = 64'(n) * PAT;
      tick();
    end
    chk("fill_valid", {56'd0, out_valid}, 64'hFF);
    in_sel    = 3'd5;
    in_data   = 64'd5 * PAT;
    clr_valid = 1'b1;
    tick();
    clr_valid = 1'b0;
    in_valid  = 1'b0;
    chk("clr_valid_keeps_5", {56'd0, out_valid}, 64'h20);
    for (int n = 0; n < 8; n++) chk($sformatf("clr_data%0d", n), outs[n], 64'(n) * PAT);

    // Stall with requests offered for four cycles
    begin
      int idx;
      idx      = 0;
      hold     = 1'b1;
      in_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
        in_sel  = 3'(1 + idx);
        in_data = 64'hA0 + 64'(idx);
        #1;
        chk("hold_in_ready", {63'd0, in_ready}, {63'd0, (BUF && c < 2)});
        tick();
        if (BUF && c < 2) idx++;
      end
      in_valid = 1'b0;
      hold     = 1'b0;
      chk("hold_no_write_valid", {56'd0, out_valid}, 64'h20);
      chk("hold_no_write_out1", out1, PAT);
      tick();
      chk("release_out1", out1, BUF ? 64'hA0 : PAT);
      chk("release_out2_pending", out2, 64'd2 * PAT);
      tick();
      chk("release_out2", out2, BUF ? 64'hA1 : 64'd2 * PAT);
    end

    // Same slot back to back: last accepted wins
    hold     = BUF;
    in_valid = 1'b1;
    in_sel   = 3'd6;
    in_data  = 64'h0000_0000_AAAA_0006;
    tick();
    in_data  = 64'h0000_0000_BBBB_0006;
    tick();
    in_valid = 1'b0;
    hold     = 1'b0;
    tick();
    tick();
    chk("same_slot_out6", out6, 64'h0000_0000_BBBB_0006);
    chk("same_slot_valid6", {63'd0, out_valid[6]}, 64'd1);

    // Asynchronous reset mid-cycle with queued writes
    hold     = 1'b1;
    in_valid = 1'b1;
    in_sel   = 3'd7;
    in_data  = 64'hC0C0_C0C0_C0C0_C0C7;
    tick();
    in_sel   = 3'd0;
    in_data  = 64'hD0D0_D0D0_D0D0_D0D0;
    tick();
    in_valid = 1'b0;
    chk("pre_reset_busy", {63'd0, busy}, {63'd0, BUF});
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("async_rst_out%0d", i), outs[i], '0);
    chk("async_rst_valid", {56'd0, out_valid}, '0);
    chk("async_rst_busy", {63'd0, busy}, '0);
    chk("async_rst_in_ready", {63'd0, in_ready}, '0);
    tick();
    reset = 1'b0;
    hold  = 1'b0;
    tick();
    tick();
    chk("post_reset_valid", {56'd0, out_valid}, '0);
    chk("post_reset_out7", out7, '0);
    chk("post_reset_out0", out0, '0);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 3'($urandom_range(0, 7));
      in_data   = {$urandom, $urandom};
      hold      = ($urandom_range(0, 3) == 0);
      clr_valid = ($urandom_range(0, 9) == 0);
      tick();
    end
    in_valid  = 1'b0;
    hold      = 1'b0;
    clr_valid = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
